// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - access size encoding (core 'size' input)
//   - FSM state enum
//   - lane geometry of the data word (LANES byte lanes of LANE_W bits)
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int DATA_W = LANES * LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational lane logic for the load/store unit.
//   size       in  access size (byte/half/word; reserved passes through)
//   offset     in  lane offset of the access, already aligned to the size
//   uns        in  1 = zero-extend loads, 0 = sign-extend
//   rd_word    in  word read from memory (load source)
//   merge_word in  previously captured memory word (sub-word store base)
//   wdata      in  right-aligned store data
//   load_data  out extracted and extended load result
//   merge_data out merge_word with the addressed lane(s) replaced by wdata
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              uns,
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] merge_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] lane_shifted;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] mask_at_lane;

  assign shamt        = {offset, 3'b000};
  assign lane_shifted = rd_word >> shamt;

  always_comb begin
    load_data = rd_word;
    lane_mask = {DATA_W{1'b1}};
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{~uns & lane_shifted[7]}}, lane_shifted[7:0]};
        lane_mask = 32'h0000_00FF;
      end
      SIZE_HALF: begin
        load_data = {{16{~uns & lane_shifted[15]}}, lane_shifted[15:0]};
        lane_mask = 32'h0000_FFFF;
      end
      default: begin
        load_data = rd_word;
        lane_mask = {DATA_W{1'b1}};
      end
    endcase
  end

  assign mask_at_lane = lane_mask << shamt;
  assign merge_data   = (merge_word & ~mask_at_lane) | ((wdata & lane_mask) << shamt);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns single byte/half/word core accesses into
// word-aligned data-memory accesses. Sub-word stores do a read-modify-write.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses instead of silently aligning them.
//   clk, rst_n            clock, async active-low reset
//   req/we/size/uns/addr/wdata  core request (sampled only while ready)
//   ready, done, rdata, err     core response
//   mem_a, mem_wd, mem_we, mem_rd  word-wide data memory port
//
// state  | meaning
// IDLE   | ready for a request; captures it when req=1
// ACCESS | memory read (load / sub-word store) or word write
// WRITE  | write back the merged word of a sub-word store
// DONE   | one-cycle completion pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  lsu_state_e state_q, state_d;

  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [1:0]  offset;
  logic        fault;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Lane offset with the low address bits forced to the access alignment.
  always_comb begin
    case (size_q)
      SIZE_HALF: offset = {addr_q[1], 1'b0};
      SIZE_WORD: offset = 2'b00;
      default:   offset = addr_q[1:0];
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((size_q == SIZE_HALF) && addr_q[0]) ||
                    ((size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00));
  assign fault    = (size_q == SIZE_RSVD) || misalign;
`else
  assign fault    = (size_q == SIZE_RSVD);
`endif

  lsu_lane_merge u_lane_merge (
    .size       (size_q),
    .offset     (offset),
    .uns        (uns_q),
    .rd_word    (mem_rd),
    .merge_word (merge_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req) state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (fault || !we_q || (size_q == SIZE_WORD)) state_d = ST_DONE;
        else                                         state_d = ST_WRITE;
      end
      ST_WRITE:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs; mem_we decodes straight from state so an async reset drops it at once.
  always_comb begin
    ready  = (state_q == ST_IDLE);
    done   = (state_q == ST_DONE);
    mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
    mem_wd = (state_q == ST_WRITE) ? merge_data : wdata_q;
    mem_we = (state_q == ST_WRITE) ||
             ((state_q == ST_ACCESS) && we_q && (size_q == SIZE_WORD) && !fault);
    rdata  = rdata_q;
    err    = err_q;
  end

  // Datapath register next values
  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          uns_d   = uns;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = 1'b0;
        end
      end
      ST_ACCESS: begin
        err_d = fault;
        if (!fault && !we_q) rdata_d = load_data;
        if (!fault && we_q && (size_q != SIZE_WORD)) merge_d = mem_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .err(err), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Data memory: 1024 words indexed by address bits [11:2], plus a backdoor port.
  logic [31:0] mem [1024];
  logic        bk_we = 1'b0;
  logic [9:0]  bk_idx = '0;
  logic [31:0] bk_data = '0;
  int          pulse_cnt = 0;

  assign mem_rd = mem[mem_a[11:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a[11:2]] <= mem_wd;
      pulse_cnt <= pulse_cnt + 1;
    end else if (bk_we) begin
      mem[bk_idx] <= bk_data;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    bk_we = 1'b1; bk_idx = idx; bk_data = data;
    @(posedge clk); #1;
    bk_we = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_fault(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((int'(a[1:0]) % nbytes_of(sz)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int ref_off(input logic [31:0] a, input logic [1:0] sz);
    int lo = int'(a[1:0]);
    return lo - (lo % nbytes_of(sz));
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic u);
    int n = nbytes_of(sz);
    logic [63:0] v;
    v = {32'd0, w} >> (8 * ref_off(a, sz));
    v = v & ((64'd1 << (8 * n)) - 64'd1);
    if (!u && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] wd);
    logic [7:0] b [4];
    int off = ref_off(a, sz);
    for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
    for (int k = 0; k < nbytes_of(sz); k++) b[off + k] = wd[8*k +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Issue one request from IDLE; returns with the DUT in DONE (or timed out).
  task automatic run_txn(input logic t_we, input logic [1:0] t_sz, input logic t_uns,
                         input logic [31:0] t_a, input logic [31:0] t_wd,
                         output int lat, output logic [31:0] a_seen);
    check("ready_before_req", {31'd0, ready}, 32'd1);
    req = 1'b1; we = t_we; size = t_sz; uns = t_uns; addr = t_a; wdata = t_wd;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    a_seen = mem_a;
    while (!done && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int          lat;
    int          p0;
    logic [31:0] a_seen;
    logic [31:0] ref_mem [8];
    logic [31:0] model_rdata;

    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0, 32'hFFFF_FFAA, 1'b0, 2, 32'h8899_AABB};
    vecs[1]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, 32'h0000_8899, 1'b0, 2, 32'h8899_AABB};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'h55, 32'h0000_8899, 1'b0, 3, 32'h5522_3344};
    vecs[3]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0000_8899, 1'b0, 2, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 32'hCAFE_F00D};
    vecs[5]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 1'b1, 2, 32'h8899_AABB};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 1'b1, 2, 32'h8899_AABB};
    vecs[7]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h0000_0088, 1'b0, 2, 32'h8899_AABB};
`else
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0101, 32'h0, 32'hFFFF_AABB, 1'b0, 2, 32'h8899_AABB};
    vecs[7]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h0000_0088, 1'b0, 2, 32'h8899_AABB};
`endif
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'hABCD_1234, 32'h0000_0088, 1'b0, 3, 32'h1234_3344};
    vecs[9]  = '{1'b1, 2'd3, 1'b0, 32'h0000_0200, 32'hFFFF_FFFF, 32'h0000_0088, 1'b1, 2, 32'h1234_3344};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_0302, 32'h1234_5678, 32'h0000_0088, 1'b1, 2, 32'hDEAD_BEEF};
`else
    vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_0302, 32'h1234_5678, 32'h0000_0088, 1'b0, 2, 32'h1234_5678};
`endif
    vecs[11] = '{1'b1, 2'd0, 1'b1, 32'h0000_0200, 32'h0000_01FF, 32'h0000_0088, 1'b0, 3, 32'h1234_33FF};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h0000_0200, 32'h0, 32'hFFFF_FFFF, 1'b0, 2, 32'h1234_33FF};

    // Reset state (reset held from time 0)
    @(posedge clk); #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);

    for (int i = 0; i < 1024; i++) preload(10'(i), 32'd0);
    preload(10'h040, 32'h8899_AABB);
    preload(10'h080, 32'h1122_3344);
    preload(10'h0C1, 32'h0BAD_CAFE);
    preload(10'h3FF, 32'hCAFE_F00D);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      p0 = pulse_cnt;
      run_txn(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, lat, a_seen);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_mem_a", i), a_seen, {vecs[i].addr[31:2], 2'b00});
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      @(posedge clk); #1;
      check($sformatf("v%0d_word", i), mem[vecs[i].addr[11:2]], vecs[i].exp_word);
      check($sformatf("v%0d_we_pulses", i), 32'(pulse_cnt - p0),
            (vecs[i].we && !vecs[i].exp_err) ? 32'd1 : 32'd0);
      check($sformatf("v%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
    end

    // Word store with a second request held during the busy cycles
    p0 = pulse_cnt;
    req = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h300; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    addr = 32'h304; wdata = 32'h1111_1111;
    check("busy_access_mem_we", {31'd0, mem_we}, 32'd1);
    check("busy_access_mem_a", mem_a, 32'h300);
    check("busy_access_mem_wd", mem_wd, 32'hDEAD_BEEF);
    check("busy_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    check("busy_done_cycle2", {31'd0, done}, 32'd1);
    check("busy_done_mem_we", {31'd0, mem_we}, 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    check("busy_ready_after", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    check("busy_no_queue", {31'd0, ready}, 32'd1);
    check("busy_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("busy_word_300", mem[10'h0C0], 32'hDEAD_BEEF);
    check("busy_word_304", mem[10'h0C1], 32'h0BAD_CAFE);

    // Reset during the WRITE phase of a byte store
    p0 = pulse_cnt;
    req = 1'b1; we = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h201; wdata = 32'hEE;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("wr_mem_we_in_write", {31'd0, mem_we}, 32'd1);
    check("wr_mem_wd_in_write", mem_wd, 32'h1234_EEFF);
    rst_n = 1'b0;
    #1;
    check("rst_mem_we_async", {31'd0, mem_we}, 32'd0);
    check("rst_ready_async", {31'd0, ready}, 32'd1);
    check("rst_rdata_async", rdata, 32'd0);
    @(posedge clk); #1;
    check("rst_word_kept", mem[10'h080], 32'h1234_33FF);
    check("rst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_release", {31'd0, ready}, 32'd1);

    // Randomized traffic against the reference model
    for (int w = 0; w < 8; w++) begin
      ref_mem[w] = $urandom;
      preload(10'(10'h100 + w), ref_mem[w]);
    end
    model_rdata = 32'd0;
    for (int t = 0; t < 200; t++) begin
      int          w;
      logic [31:0] a, wd;
      logic [1:0]  sz;
      logic        t_we, t_u;
      bit          f;
      w    = $urandom_range(0, 7);
      a    = 32'h400 + 32'(w * 4) + 32'($urandom_range(0, 3));
      sz   = 2'($urandom_range(0, 3));
      t_we = 1'($urandom_range(0, 1));
      t_u  = 1'($urandom_range(0, 1));
      wd   = $urandom;
      f    = ref_fault(a, sz);
      p0   = pulse_cnt;
      run_txn(t_we, sz, t_u, a, wd, lat, a_seen);
      if (!f && !t_we) model_rdata = ref_load(ref_mem[w], a, sz, t_u);
      if (!f && t_we)  ref_mem[w]  = ref_store(ref_mem[w], a, sz, wd);
      check("rnd_latency", 32'(lat), (!f && t_we && sz != 2'd2) ? 32'd3 : 32'd2);
      check("rnd_mem_a", a_seen, {a[31:2], 2'b00});
      check("rnd_err", {31'd0, err}, {31'd0, f});
      check("rnd_rdata", rdata, model_rdata);
      @(posedge clk); #1;
      check("rnd_word", mem[10'h100 + 10'(w)], ref_mem[w]);
      check("rnd_we_pulses", 32'(pulse_cnt - p0), (t_we && !f) ? 32'd1 : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
